// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, instruction field offsets, fetch FSM state type
// and a helper that packs the ROM field outputs into one instruction word.
package fetch_pkg;

    localparam int INSTR_W  = 9;
    localparam int PC_W     = 16;

    localparam int FMT_BIT  = 8;
    localparam int OPC_HI   = 7;
    localparam int OPC_LO   = 4;
    localparam int SIGN_BIT = 3;
    localparam int OPR_HI   = 2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic       fmt,
        input logic [3:0] opc,
        input logic       sgn,
        input logic [2:0] opr
    );
        logic [INSTR_W-1:0] w;
        w                 = '0;
        w[FMT_BIT]        = fmt;
        w[OPC_HI:OPC_LO]  = opc;
        w[SIGN_BIT]       = sgn;
        w[OPR_HI:0]       = opr;
        return w;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// pc_gen: program counter register.
//   clk, rst_n    - clock, synchronous active-low reset
//   redirect      - load br_target (highest priority)
//   br_target     - redirect PC
//   advance       - step PC by one, wrapping 0xFFFF -> 0x0000
//   pc            - current PC
//   at_end        - PC is at or beyond PROG_LEN
module pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned PROG_LEN = 35
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [PC_W-1:0] br_target,
    input  logic            advance,
    output logic [PC_W-1:0] pc,
    output logic            at_end
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc <= '0;
        else if (redirect)
            pc <= br_target;
        else if (advance)
            pc <= pc + 1'b1;   // natural 16-bit wrap
    end

    // 32-bit compare so PROG_LEN may exceed the PC range (never ends).
    assign at_end = ({16'd0, pc} >= PROG_LEN);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: drives the ROM PC, captures the combinational ROM fields into a
// one-entry instruction slot and hands it to decode over valid/ready.
//   clk, rst_n         - clock, synchronous active-low reset
//   pc_out             - ROM address (internal PC)
//   rom_format/opcode/sign/operand - ROM field outputs for pc_out
//   br_valid/br_target - redirect request (wins over everything)
//   ir_valid/ir_ready  - slot handshake to decode
//   ir_instr, ir_pc    - slot contents
//   halted             - fetch stopped
// Optional macro HALT_DETECT_EN: a fetched HALT_WORD is delivered, then fetch
// stops with the PC parked on the halt word.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        PROG_LEN  = 35,
    parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    pc_out,
    input  logic               rom_format,
    input  logic [3:0]         rom_opcode,
    input  logic               rom_sign,
    input  logic [2:0]         rom_operand,
    input  logic               br_valid,
    input  logic [PC_W-1:0]    br_target,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_instr,
    output logic [PC_W-1:0]    ir_pc,
    output logic               halted
);

`ifdef HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_t       state, state_nxt;
    logic [PC_W-1:0]    pc;
    logic               at_end;
    logic               fetch;
    logic               halt_hit;
    logic [INSTR_W-1:0] rom_word;

    assign rom_word = pack_instr(rom_format, rom_opcode, rom_sign, rom_operand);
    assign halt_hit = HALT_EN && (rom_word == HALT_WORD);

    assign fetch = (state == RUN) && !br_valid && !at_end && (!ir_valid || ir_ready);

    pc_gen #(.PROG_LEN(PROG_LEN)) u_pc_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .redirect  (br_valid),
        .br_target (br_target),
        .advance   (fetch && !halt_hit),
        .pc        (pc),
        .at_end    (at_end)
    );

    assign pc_out = pc;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (br_valid)
            state_nxt = RUN;
        else if (state == RUN && (at_end || (fetch && halt_hit)))
            state_nxt = HALTED;
    end

    // FSM: outputs
    always_comb begin
        halted = (state == HALTED);
    end

    // Instruction slot. A redirect flushes even an unaccepted slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_valid <= 1'b0;
            ir_instr <= '0;
            ir_pc    <= '0;
        end else if (br_valid) begin
            ir_valid <= 1'b0;
        end else if (fetch) begin
            ir_valid <= 1'b1;
            ir_instr <= rom_word;
            ir_pc    <= pc;
        end else if (ir_ready) begin
            ir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test of instr_fetch with a small ROM model.
// u_dut uses PROG_LEN=35; u_ffff (PROG_LEN=0xFFFF) and u_wrap (PROG_LEN=65536)
// share the stimulus and cover the top-of-address-space cases.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic [15:0] br_target;
    logic        ir_ready;

    logic [15:0] pc_a, pc_b, pc_c;
    logic [8:0]  rw_a, rw_b, rw_c;
    logic        v_a, v_b, v_c, h_a, h_b, h_c;
    logic [8:0]  i_a, i_b, i_c;
    logic [15:0] p_a, p_b, p_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ROM model: a few hand-placed words, otherwise {0, pc[7:0]}.
    function automatic logic [8:0] rom(input logic [15:0] pc);
        case (pc)
            16'd1:   return 9'b100010000;
            16'd5:   return 9'b100000001;
            16'd7:   return 9'h1FF;
            16'd20:  return 9'b100010010;
            default: return {1'b0, pc[7:0]};
        endcase
    endfunction

    assign rw_a = rom(pc_a);
    assign rw_b = rom(pc_b);
    assign rw_c = rom(pc_c);

    instr_fetch #(.PROG_LEN(35)) u_dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_a),
        .rom_format(rw_a[8]), .rom_opcode(rw_a[7:4]), .rom_sign(rw_a[3]), .rom_operand(rw_a[2:0]),
        .br_valid(br_valid), .br_target(br_target),
        .ir_valid(v_a), .ir_ready(ir_ready), .ir_instr(i_a), .ir_pc(p_a), .halted(h_a)
    );

    instr_fetch #(.PROG_LEN(32'hFFFF)) u_ffff (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_b),
        .rom_format(rw_b[8]), .rom_opcode(rw_b[7:4]), .rom_sign(rw_b[3]), .rom_operand(rw_b[2:0]),
        .br_valid(br_valid), .br_target(br_target),
        .ir_valid(v_b), .ir_ready(ir_ready), .ir_instr(i_b), .ir_pc(p_b), .halted(h_b)
    );

    instr_fetch #(.PROG_LEN(32'h10000)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_c),
        .rom_format(rw_c[8]), .rom_opcode(rw_c[7:4]), .rom_sign(rw_c[3]), .rom_operand(rw_c[2:0]),
        .br_valid(br_valid), .br_target(br_target),
        .ir_valid(v_c), .ir_ready(ir_ready), .ir_instr(i_c), .ir_pc(p_c), .halted(h_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_target = '0; ir_ready = 1'b0;
        step(); step();

        // reset state
        chk("rst_pc", pc_a, 0);
        chk("rst_valid", v_a, 0);
        chk("rst_instr", i_a, 0);
        chk("rst_irpc", p_a, 0);
        chk("rst_halted", h_a, 0);

        // streaming fetch 0..34 with ir_ready held
        rst_n = 1'b1; ir_ready = 1'b1;
        for (int i = 0; i < 35; i++) begin
            step();
            chk("seq_valid", v_a, 1);
            chk("seq_irpc", p_a, i);
            chk("seq_instr", i_a, rom(16'(i)));
`ifdef HALT_DETECT_EN
            if (i == 7) break;
`endif
        end
`ifdef HALT_DETECT_EN
        chk("hw_halted", h_a, 1);
        chk("hw_pc_hold", pc_a, 7);
        step();
        chk("hw_pc_hold2", pc_a, 7);
`else
        chk("seq_at_end_not_halted", h_a, 0);
        step();
        chk("end_halted", h_a, 1);
        chk("end_valid", v_a, 0);
        chk("end_pc", pc_a, 35);
`endif

        // redirect out of HALTED to 0, then stall at pc 5
        br_valid = 1'b1; br_target = 16'd0;
        step();
        chk("rd_halted", h_a, 0);
        chk("rd_pc", pc_a, 0);
        chk("rd_valid", v_a, 0);
        br_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("stall_irpc0", p_a, 5);
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_irpc", p_a, 5);
            chk("stall_instr", i_a, 9'b100000001);
            chk("stall_pc", pc_a, 6);
            chk("stall_valid", v_a, 1);
        end
        ir_ready = 1'b1;
        step();
        chk("resume_irpc", p_a, 6);

        // redirect flushes an unaccepted slot
        ir_ready = 1'b0; br_valid = 1'b1; br_target = 16'd20;
        step();
        chk("flush_valid", v_a, 0);
        chk("flush_pc", pc_a, 20);
        br_valid = 1'b0;
        step();
        chk("br_irpc", p_a, 20);
        chk("br_instr", i_a, 9'b100010010);
        chk("br_valid", v_a, 1);

        // redirect together with ir_ready: redirect wins, no fetch
        ir_ready = 1'b1; br_valid = 1'b1; br_target = 16'd10;
        step();
        chk("rdy_br_valid", v_a, 0);
        chk("rdy_br_pc", pc_a, 10);
        br_valid = 1'b0;

        // run to end of program (bounded)
        for (int i = 0; i < 40 && !h_a; i++) step();
        chk("run_end_halted", h_a, 1);
        chk("run_end_pc", pc_a, 35);
        br_valid = 1'b1; br_target = 16'd0;
        step();
        chk("restart_halted", h_a, 0);
        br_valid = 1'b0;
        step();
        chk("restart_irpc", p_a, 0);
        chk("restart_valid", v_a, 1);

        // top of address space
        br_valid = 1'b1; br_target = 16'hFFFE;
        step();
        br_valid = 1'b0;
        step();
        chk("ffff_irpc", p_b, 16'hFFFE);
        chk("ffff_pc", pc_b, 16'hFFFF);
        step();
        chk("ffff_halted", h_b, 1);
        chk("ffff_pc_hold", pc_b, 16'hFFFF);
        chk("wrap_irpc", p_c, 16'hFFFF);
        chk("wrap_pc", pc_c, 16'h0000);
        chk("wrap_halted", h_c, 0);
        step();
        chk("wrap_irpc0", p_c, 16'h0000);
        chk("wrap_instr0", i_c, rom(16'h0000));

        // reset in the middle of a redirect
        rst_n = 1'b0; br_valid = 1'b1; br_target = 16'd5;
        step();
        chk("rst2_pc", pc_a, 0);
        chk("rst2_valid", v_a, 0);
        chk("rst2_halted", h_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
